// File: rtl/mod_updown_counter.sv
// Modulo-MODULO up/down counter with load and registered terminal-count pulse; `COUNTER_SAT_EN selects saturate instead of wrap.
// Latency 1 clk from sampled inputs to count/tc; no backpressure, inputs are taken every enabled edge.
module mod_updown_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // One extra bit so MODULO == 2**WIDTH is representable in the load clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] count_d, count_q;
    logic             tc_d, tc_q;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            if ({1'b0, load_val} >= MOD_EXT) begin
                count_d = MAX_VAL;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (count_q == MAX_VAL) begin
                    tc_d = 1'b1;
`ifdef COUNTER_SAT_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
`ifdef COUNTER_SAT_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector bench for mod_updown_counter: MODULO=10 and MODULO=16 instances, WIDTH=4.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic       en16, up_dn16, load16;
    logic [3:0] load_val16;
    logic [3:0] count16;
    logic       tc16;

    int n_chk  = 0;
    int n_pass = 0;

    mod_updown_counter #(.WIDTH(4), .MODULO(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en16),
        .up_dn    (up_dn16),
        .load     (load16),
        .load_val (load_val16),
        .count    (count16),
        .tc       (tc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input int exp_cnt, input int exp_tc);
        chk({tag, ".count"}, int'(count), exp_cnt);
        chk({tag, ".tc"}, int'(tc), exp_tc);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
        en16 = 1'b0; up_dn16 = 1'b1; load16 = 1'b0; load_val16 = '0;
        #1;
        chk_both("rst_async", 0, 0);
        step();
        step();
        chk_both("rst_hold", 0, 0);
        chk("rst_hold16.count", int'(count16), 0);

        // 1: 12 up steps after reset release
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_both($sformatf("up%0d", i), (i + 1) % 10, (i == 9) ? 1 : 0);
        end

        // 2: load 7 then 9 downs through the 0 -> 9 wrap
        load = 1'b1; load_val = 4'd7;
        step();
        chk_both("load7", 7, 0);
        load = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk_both($sformatf("dn%0d", i), (i < 7) ? (6 - i) : (16 - i), (i == 7) ? 1 : 0);
        end
        load = 1'b1; load_val = 4'd13;
        step();
        chk_both("load13_clamp", 9, 0);
        load_val = 4'd15;
        step();
        chk_both("load15_clamp", 9, 0);

        // 3: hold then direction toggles with no dead cycle
        load_val = 4'd4; up_dn = 1'b1;
        step();
        load = 1'b0;
        step();
        chk_both("to5", 5, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_both($sformatf("hold%0d", i), 5, 0);
        end
        en = 1'b1; up_dn = 1'b1;
        step();
        chk_both("tog_up", 6, 0);
        up_dn = 1'b0;
        step();
        chk_both("tog_dn0", 5, 0);
        step();
        chk_both("tog_dn1", 4, 0);

        // 4: load beats en at the terminal value
        load = 1'b1; load_val = 4'd9; up_dn = 1'b1;
        step();
        chk_both("load9", 9, 0);
        load_val = 4'd2;
        step();
        chk_both("load_wins", 2, 0);

        // 5: mid-cycle asynchronous reset at count 6
        load_val = 4'd6;
        step();
        load = 1'b0; en = 1'b0;
        chk_both("load6", 6, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_both("rst_mid", 0, 0);
        #2 rst_n = 1'b1;
        step();
        chk_both("rst_mid_after", 0, 0);

        // MODULO=16: natural binary wrap, then a down wrap
        en16 = 1'b1; up_dn16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("m16_up%0d.count", i), int'(count16), (i + 1) % 16);
            chk($sformatf("m16_up%0d.tc", i), int'(tc16), (i == 15) ? 1 : 0);
        end
        up_dn16 = 1'b0;
        step();
        chk("m16_dn.count", int'(count16), 15);
        chk("m16_dn.tc", int'(tc16), 1);
        en16 = 1'b0;
        step();
        chk("m16_hold.tc", int'(tc16), 0);

        // 6: repeated steps past the limits (saturate or wrap by build)
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
`ifdef COUNTER_SAT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk_both($sformatf("sat_up%0d", i), 9, 1);
        end
`else
        step();
        chk_both("lim_up0", 0, 1);
        step();
        chk_both("lim_up1", 1, 0);
        step();
        chk_both("lim_up2", 2, 0);
`endif
        load = 1'b1; load_val = 4'd0;
        step();
        chk_both("load0", 0, 0);
        load = 1'b0; up_dn = 1'b0;
        step();
`ifdef COUNTER_SAT_EN
        chk_both("sat_dn", 0, 1);
`else
        chk_both("lim_dn", 9, 1);
`endif
        en = 1'b0;
        step();
        chk("tc_clear", int'(tc), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
